// File: rtl/rc_wormhole_pipe.sv
// rc_wormhole_pipe
//   Registered route-computation stage for one input port of a 2D-mesh
//   router. A head flit computes a preferred-port vector (XY, YX or minimal
//   adaptive). Body and tail flits reuse the route latched from their head.
//   A single output register with valid/ready flow control sits between the
//   input buffer and the switch allocator.
//
// Handshake: a transfer happens on a port in any cycle where valid and ready
//   are both high. in_ready = ~out_valid | out_ready, so the register can
//   reload in the same cycle its contents leave. out_* hold steady while
//   out_valid & ~out_ready.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   cfg_mode          0=XY 1=YX 2=minimal adaptive 3=XY (sampled on head accept)
//   in_valid/in_ready input handshake
//   in_head/in_tail   framing bits
//   in_dst            destination {y,x}, only meaningful on a head
//   in_data           payload, passed through unchanged
//   out_valid/out_ready output handshake
//   out_ppv           [0]=N(y+) [1]=E(x+) [2]=S(y-) [3]=W(x-) [4]=local
//   out_head/out_tail/out_data  registered flit fields
//   err_range         sticky: head with an out-of-mesh destination
//   err_proto         sticky: framing violation
//   pkt_cnt           tails forwarded downstream, wraps
//   fsm_state         wormhole state for observation (0=IDLE, 1=BODY)
module rc_wormhole_pipe #(
    parameter int CORD_X  = 1,
    parameter int CORD_Y  = 1,
    parameter int COORD_W = 4,
    parameter int MESH_X  = 4,
    parameter int MESH_Y  = 4,
    parameter int DATA_W  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           cfg_mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_head,
    input  logic                 in_tail,
    input  logic [2*COORD_W-1:0] in_dst,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4:0]           out_ppv,
    output logic                 out_head,
    output logic                 out_tail,
    output logic [DATA_W-1:0]    out_data,
    output logic                 err_range,
    output logic                 err_proto,
    output logic [15:0]          pkt_cnt,
    output logic                 fsm_state
);

    typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

    localparam logic [COORD_W-1:0] OWN_X = COORD_W'(CORD_X);
    localparam logic [COORD_W-1:0] OWN_Y = COORD_W'(CORD_Y);
    localparam logic [4:0]         PPV_LOCAL = 5'b10000;

    state_t             state, state_nxt;
    logic [4:0]         route_q;
    logic [COORD_W-1:0] dst_x, dst_y;
    logic               in_range;
    logic               go_n, go_e, go_s, go_w;
    logic [4:0]         head_ppv;
    logic               accept, xfer;
    logic               load, proto_hit;
    logic [4:0]         load_ppv;

    assign fsm_state = state;
    assign in_ready  = ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;

    assign dst_x    = in_dst[COORD_W-1:0];
    assign dst_y    = in_dst[2*COORD_W-1:COORD_W];
    assign in_range = (int'(dst_x) < MESH_X) && (int'(dst_y) < MESH_Y);

    assign go_e = dst_x > OWN_X;
    assign go_w = dst_x < OWN_X;
    assign go_n = dst_y > OWN_Y;
    assign go_s = dst_y < OWN_Y;

    // Route for a head flit. Out-of-mesh destinations eject locally so the
    // flit is drained rather than wandering off the mesh edge.
    always_comb begin
        head_ppv = PPV_LOCAL;
        if (in_range && !(dst_x == OWN_X && dst_y == OWN_Y)) begin
            case (cfg_mode)
                2'd1: begin
                    if (go_n || go_s) head_ppv = {1'b0, 1'b0, go_s, 1'b0, go_n};
                    else              head_ppv = {1'b0, go_w, 1'b0, go_e, 1'b0};
                end
                2'd2: head_ppv = {1'b0, go_w, go_s, go_e, go_n};
                default: begin
                    if (go_e || go_w) head_ppv = {1'b0, go_w, 1'b0, go_e, 1'b0};
                    else              head_ppv = {1'b0, 1'b0, go_s, 1'b0, go_n};
                end
            endcase
        end
    end

    // Wormhole FSM next state and load decision. A head in BODY is a framing
    // error but is still treated as the start of a fresh packet; a non-head
    // in IDLE is swallowed without reaching the output register.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        proto_hit = 1'b0;
        load_ppv  = head_ppv;
        if (accept) begin
            if (in_head) begin
                load      = 1'b1;
                proto_hit = (state == BODY);
                state_nxt = in_tail ? IDLE : BODY;
            end else if (state == IDLE) begin
                proto_hit = 1'b1;
            end else begin
                load     = 1'b1;
                load_ppv = route_q;
                if (in_tail) state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_ppv   <= '0;
            out_head  <= 1'b0;
            out_tail  <= 1'b0;
            out_data  <= '0;
            route_q   <= '0;
            err_range <= 1'b0;
            err_proto <= 1'b0;
            pkt_cnt   <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_ppv   <= load_ppv;
                out_head  <= in_head;
                out_tail  <= in_tail;
                out_data  <= in_data;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
            if (accept && in_head) begin
                route_q <= head_ppv;
                if (!in_range) err_range <= 1'b1;
            end
            if (proto_hit) err_proto <= 1'b1;
            if (xfer && out_tail) pkt_cnt <= pkt_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_rc_wormhole_pipe.sv
// Bench for rc_wormhole_pipe (CORD=(1,1), 4x4 mesh, 4-bit coordinates).
// Directed scenarios followed by a randomized phase, all compared against a
// packet-level reference model: expected flits wait in exp_q until they
// leave the output port.
module tb_rc_wormhole_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cfg_mode = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_head = 1'b0;
    logic        in_tail = 1'b0;
    logic [7:0]  in_dst = '0;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_ppv;
    logic        out_head;
    logic        out_tail;
    logic [31:0] out_data;
    logic        err_range;
    logic        err_proto;
    logic [15:0] pkt_cnt;
    logic        fsm_state;

    rc_wormhole_pipe #(
        .CORD_X(1), .CORD_Y(1), .COORD_W(4), .MESH_X(4), .MESH_Y(4), .DATA_W(32)
    ) dut (
        .clk(clk), .reset(reset), .cfg_mode(cfg_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_head(in_head),
        .in_tail(in_tail), .in_dst(in_dst), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ppv(out_ppv),
        .out_head(out_head), .out_tail(out_tail), .out_data(out_data),
        .err_range(err_range), .err_proto(err_proto), .pkt_cnt(pkt_cnt),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // exp_q entry: {ppv[38:34], head[33], tail[32], data[31:0]}
    logic [38:0] exp_q[$];
    logic        m_in_pkt;
    logic [4:0]  m_ppv;
    logic        m_err_range;
    logic        m_err_proto;
    logic [15:0] m_cnt;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [4:0] ref_route(input int dx, input int dy, input int mode);
        logic [4:0] xb, yb;
        if (dx >= 4 || dy >= 4) return 5'b10000;
        if (dx == 1 && dy == 1) return 5'b10000;
        xb = (dx > 1) ? 5'b00010 : (dx < 1) ? 5'b01000 : 5'b00000;
        yb = (dy > 1) ? 5'b00001 : (dy < 1) ? 5'b00100 : 5'b00000;
        if (mode == 1) return (yb != 0) ? yb : xb;
        if (mode == 2) return xb | yb;
        return (xb != 0) ? xb : yb;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_in_pkt    = 1'b0;
        m_ppv       = '0;
        m_err_range = 1'b0;
        m_err_proto = 1'b0;
        m_cnt       = '0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
    endtask

    // One clock: drive, check outputs at negedge, advance model at posedge.
    task automatic step(input logic v, input logic h, input logic t,
                        input int dx, input int dy, input logic [31:0] d,
                        input logic [1:0] m, input logic ordy);
        logic        exp_rdy, acc, xf;
        logic [38:0] f;
        logic [4:0]  p;
        in_valid  = v;
        in_head   = h;
        in_tail   = t;
        in_dst    = {4'(dy), 4'(dx)};
        in_data   = d;
        cfg_mode  = m;
        out_ready = ordy;
        @(negedge clk);
        exp_rdy = (exp_q.size() == 0) || ordy;
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            f = exp_q[0];
            check("out_ppv", out_ppv, f[38:34]);
            check("out_head", out_head, f[33]);
            check("out_tail", out_tail, f[32]);
            check("out_data", out_data, f[31:0]);
        end
        check("err_range", err_range, m_err_range);
        check("err_proto", err_proto, m_err_proto);
        check("pkt_cnt", pkt_cnt, m_cnt);
        check("fsm_state", fsm_state, m_in_pkt);
        @(posedge clk);
        acc = v & exp_rdy;
        xf  = (exp_q.size() != 0) & ordy;
        if (xf) begin
            f = exp_q.pop_front();
            if (f[32]) m_cnt = m_cnt + 16'd1;
        end
        if (acc) begin
            if (h) begin
                if (m_in_pkt) m_err_proto = 1'b1;
                if (dx >= 4 || dy >= 4) m_err_range = 1'b1;
                p        = ref_route(dx, dy, int'(m));
                m_ppv    = p;
                m_in_pkt = !t;
                exp_q.push_back({p, h, t, d});
            end else if (!m_in_pkt) begin
                m_err_proto = 1'b1;
            end else begin
                exp_q.push_back({m_ppv, h, t, d});
                if (t) m_in_pkt = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0, 2'd0, 1'b1);
    endtask

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_ppv", out_ppv, 5'b0);
        check("rst_out_head", out_head, 1'b0);
        check("rst_out_tail", out_tail, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_err", {err_range, err_proto}, 2'b00);
        check("rst_pkt_cnt", pkt_cnt, 16'h0);
        check("rst_state", fsm_state, 1'b0);
        @(posedge clk);
        #1;

        // single-flit packets, three modes plus own coordinate
        step(1, 1, 1, 3, 0, 32'hA000_0001, 2'd0, 1'b1);
        step(1, 1, 1, 3, 0, 32'hA000_0002, 2'd1, 1'b1);
        step(1, 1, 1, 3, 0, 32'hA000_0003, 2'd2, 1'b1);
        step(1, 1, 1, 1, 1, 32'hA000_0004, 2'd2, 1'b1);
        step(1, 1, 1, 2, 3, 32'hA000_0005, 2'd3, 1'b1);
        idle(2);

        // 4-flit packet, mode switched to YX after the head
        step(1, 1, 0, 0, 2, 32'hB000_0000, 2'd0, 1'b1);
        step(1, 0, 0, 3, 3, 32'hB000_0001, 2'd1, 1'b1);
        step(1, 0, 0, 3, 3, 32'hB000_0002, 2'd1, 1'b1);
        step(1, 0, 1, 3, 3, 32'hB000_0003, 2'd1, 1'b1);
        idle(2);

        // backpressure: 2 flits offered while out_ready low for 3 cycles
        step(1, 1, 0, 2, 2, 32'hC000_0000, 2'd2, 1'b0);
        step(1, 0, 1, 0, 0, 32'hC000_0001, 2'd2, 1'b0);
        step(1, 0, 1, 0, 0, 32'hC000_0001, 2'd2, 1'b0);
        step(1, 0, 1, 0, 0, 32'hC000_0001, 2'd2, 1'b1);
        idle(2);

        // out-of-mesh destination, sticky error
        step(1, 1, 1, 5, 0, 32'hD000_0000, 2'd0, 1'b1);
        idle(3);

        // body flit in IDLE, head inside a packet, reset mid-packet
        step(1, 0, 0, 0, 0, 32'hE000_0000, 2'd0, 1'b1);
        step(1, 1, 0, 0, 0, 32'hE000_0001, 2'd0, 1'b1);
        step(1, 1, 0, 3, 3, 32'hE000_0002, 2'd1, 1'b0);
        do_reset();
        step(1, 1, 1, 0, 1, 32'hE000_0003, 2'd0, 1'b1);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 5), $urandom_range(0, 5),
                     $urandom,
                     2'($urandom_range(0, 3)),
                     $urandom_range(0, 3) != 0);
            end
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
